seg7_scan_reader: RTL

Receive-side counterpart of the team's BCD-to-7-segment encoder. Samples a multiplexed, active-high 7-segment bus (segment lines plus one-hot digit enables), requires each digit pattern to be stable for a set number of cycles, and decodes it back to a 4-bit value. Assembles one value per digit into a frame and hands the frame downstream over a valid/ready handshake. Used to read back and check display drive, and to sniff external 7-segment panels.

---
 rtl/seg7_scan_reader.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
// Samples a multiplexed active-high 7-segment bus, accepts a digit once its
// pattern has been stable for STABLE_CYCLES consecutive samples, decodes it
// back to a nibble and assembles one nibble per digit into a frame that is
// handed downstream over a valid/ready handshake.
module seg7_scan_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:6]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] frame_bcd,
  output logic [NUM_DIGITS-1:0]   frame_err
);

  localparam int          IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0]  STABLE    = 4'(STABLE_CYCLES);
  localparam logic [3:0]  STABLE_M1 = 4'(STABLE_CYCLES - 1);

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

  // Run tracking state
  logic [0:6]            last_seg;
  logic [NUM_DIGITS-1:0] last_dig;
  logic [3:0]            cnt;
  logic [3:0]            cnt_next;
  logic                  sample_ok;
  logic                  same_run;
  logic                  commit;

  // Decoded view of the current sample
  logic [IDX_W-1:0]      dig_idx;
  logic [3:0]            dec_val;
  logic                  dec_err;

  // Staging area for the frame under construction
  logic [4*NUM_DIGITS-1:0] stage_bcd;
  logic [NUM_DIGITS-1:0]   stage_err;
  logic [NUM_DIGITS-1:0]   filled;
  logic [NUM_DIGITS-1:0]   filled_next;

  // Output handshake state
  out_state_t            state;
  out_state_t            state_next;
  logic                  transfer;

  // Classify the sample and advance the saturating run counter.
  // A run commits exactly once: on the step from STABLE-1 to STABLE, or on the
  // run's first sample when a single sample is enough.
  always_comb begin
    sample_ok = $onehot(dig_en);
    same_run  = sample_ok && (cnt != 4'd0) &&
                (seg_in == last_seg) && (dig_en == last_dig);
    cnt_next  = '0;
    commit    = 1'b0;
    if (!sample_ok) begin
      cnt_next = '0;
    end else if (same_run) begin
      commit   = (cnt == STABLE_M1);
      cnt_next = (cnt >= STABLE) ? STABLE : cnt + 4'd1;
    end else begin
      cnt_next = 4'd1;
      commit   = (STABLE_CYCLES == 1);
    end
  end

  // Register the run counter and the pattern that started the current run.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      last_seg <= '0;
      last_dig <= '0;
    end else begin
      cnt <= cnt_next;
      if (sample_ok && !same_run) begin
        last_seg <= seg_in;
        last_dig <= dig_en;
      end
    end
  end

  // Convert the one-hot digit enable into a slot index.
  always_comb begin
    dig_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (dig_en[i]) dig_idx = IDX_W'(i);
    end
  end

  // Segment pattern to nibble; dash reads as F, anything unknown as E with err.
  always_comb begin
    dec_val = 4'hE;
    dec_err = 1'b0;
    case (seg_in)
      7'b1111110: dec_val = 4'h0;
      7'b0110000: dec_val = 4'h1;
      7'b1101101: dec_val = 4'h2;
      7'b1111001: dec_val = 4'h3;
      7'b0110011: dec_val = 4'h4;
      7'b1011011: dec_val = 4'h5;
      7'b1011111: dec_val = 4'h6;
      7'b1110000: dec_val = 4'h7;
      7'b1111111: dec_val = 4'h8;
      7'b1111011: dec_val = 4'h9;
      7'b0000001: dec_val = 4'hF;
      default: begin
        dec_val = 4'hE;
        dec_err = 1'b1;
      end
    endcase
  end

  // Filled mask: a transfer empties it first, then this edge's commit lands in
  // the fresh frame.
  always_comb begin
    filled_next = transfer ? '0 : filled;
    if (commit) filled_next[dig_idx] = 1'b1;
  end

  // Write committed digits into their staging slot (later commits overwrite).
  always_ff @(posedge clk) begin
    if (rst) begin
      filled    <= '0;
      stage_bcd <= '0;
      stage_err <= '0;
    end else begin
      filled <= filled_next;
      if (commit) begin
        stage_bcd[{dig_idx, 2'b00} +: 4] <= dec_val;
        stage_err[dig_idx]               <= dec_err;
      end
    end
  end

  // Output handshake state register.
  always_ff @(posedge clk) begin
    if (rst) state <= OUT_EMPTY;
    else     state <= state_next;
  end

  // Transfer when staging is complete and the output slot is free or being
  // drained this cycle; holding stays put until frame_ready.
  always_comb begin
    state_next = state;
    transfer   = (&filled) && ((state == OUT_EMPTY) || frame_ready);
    case (state)
      OUT_EMPTY: if (transfer) state_next = OUT_FULL;
      OUT_FULL: begin
        if (transfer)         state_next = OUT_FULL;
        else if (frame_ready) state_next = OUT_EMPTY;
      end
      default: state_next = OUT_EMPTY;
    endcase
  end

  // Output frame register, loaded from staging on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_bcd <= '0;
      frame_err <= '0;
    end else if (transfer) begin
      frame_bcd <= stage_bcd;
      frame_err <= stage_err;
    end
  end

  assign frame_valid = (state == OUT_FULL);

endmodule
